ram_bus_arbiter: RTL and testbench

- Shares the single-port data RAM between the instruction-fetch requester (IF) and the load/store requester (MEM).
- Sequences every access and converts sub-word stores into read-modify-write pairs, so the MEM stage only supplies byte enables.
- Sits between the pipeline (if / mem stages plus the stall controller) and the RAM bus.
- Fixed priority to MEM, with a starvation guard for IF.

---
 rtl/ram_bus_arbiter_pkg.sv | 23 ++
 rtl/ram_bus_arbiter_byte_merge.sv | 18 +
 rtl/ram_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ram_bus_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bus_arbiter_pkg.sv
// Shared types and constants for the RAM bus arbiter: FSM encoding, bus enables,
// byte-enable patterns and the starvation counter helper.
package ram_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IF_RD  = 3'd1,
    MEM_RD = 3'd2,
    RMW_WR = 3'd3,
    WR_ACK = 3'd4
  } state_e;

  localparam int         STARVE_LIMIT_DEF = 4;
  localparam logic       CHIP_ENABLE      = 1'b1;
  localparam logic       WRITE_ENABLE     = 1'b1;
  localparam logic [3:0] BE_FULL          = 4'b1111;
  localparam logic [3:0] BE_NONE          = 4'b0000;

  function automatic logic [3:0] starve_inc(input logic [3:0] cnt, input logic [3:0] limit);
    return (cnt >= limit) ? limit : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/ram_bus_arbiter_byte_merge.sv
// Combinational byte-lane merge: lanes with be set take the new word, others keep the old.
module byte_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_word,
  input  logic [3:0]        be,
  output logic [DATA_W-1:0] merged_word
);

  localparam int LANE_W = DATA_W / 4;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged_word[i*LANE_W +: LANE_W] = be[i] ? new_word[i*LANE_W +: LANE_W]
                                                   : old_word[i*LANE_W +: LANE_W];
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Arbitrates the single-port data RAM between instruction fetch and load/store,
// MEM-first with an IF starvation guard; partial stores become read-modify-write.
module ram_bus_arbiter
  import ram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic [DATA_W-1:0] if_rdata_out,
  output logic              if_ack_out,
  input  logic              mem_req_in,
  input  logic              mem_we_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [DATA_W-1:0] mem_wdata_in,
  input  logic [3:0]        mem_be_in,
  output logic [DATA_W-1:0] mem_rdata_out,
  output logic              mem_ack_out,
  output logic              if_stall_out,
  output logic              mem_stall_out,
  output logic              ram_ce_out,
  output logic              ram_we_out,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic [DATA_W-1:0] ram_data_out,
  input  logic [DATA_W-1:0] ram_data_in
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e            state_q, state_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;

  logic              grant_if, grant_mem;
  logic [ADDR_W-1:0] mem_addr_aligned;
  logic [DATA_W-1:0] merged;

  logic              ce_c, we_c, if_ack_c, mem_ack_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] data_c, if_rdata_c, mem_rdata_c;

  assign mem_addr_aligned = mem_addr_in & ~(ADDR_W'(3));
  assign grant_if         = if_req_in & (~mem_req_in | (starve_cnt_q == LIMIT));
  assign grant_mem        = mem_req_in & ~grant_if;

  byte_merge #(.DATA_W(DATA_W)) u_merge (
    .old_word    (ram_data_in),
    .new_word    (wdata_q),
    .be          (be_q),
    .merged_word (merged)
  );

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
    end
  end

  // MEM request fields are captured at grant so a dropped request still completes cleanly.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    ce_c         = 1'b0;
    we_c         = 1'b0;
    addr_c       = '0;
    data_c       = '0;
    if_ack_c     = 1'b0;
    mem_ack_c    = 1'b0;
    if_rdata_c   = '0;
    mem_rdata_c  = '0;

    case (state_q)
      IDLE: begin
        if (grant_if) begin
          ce_c         = CHIP_ENABLE;
          addr_c       = if_addr_in;
          starve_cnt_d = '0;
          state_d      = IF_RD;
        end else if (grant_mem) begin
          addr_d       = mem_addr_aligned;
          wdata_d      = mem_wdata_in;
          be_d         = mem_be_in;
          starve_cnt_d = if_req_in ? starve_inc(starve_cnt_q, LIMIT) : 4'd0;
          if (!mem_we_in) begin
            ce_c    = CHIP_ENABLE;
            addr_c  = mem_addr_aligned;
            state_d = MEM_RD;
          end else if (mem_be_in == BE_FULL) begin
            ce_c    = CHIP_ENABLE;
            we_c    = WRITE_ENABLE;
            addr_c  = mem_addr_aligned;
            data_c  = mem_wdata_in;
            state_d = WR_ACK;
          end else if (mem_be_in == BE_NONE) begin
            state_d = WR_ACK;
          end else begin
            ce_c    = CHIP_ENABLE;
            addr_c  = mem_addr_aligned;
            state_d = RMW_WR;
          end
        end else begin
          starve_cnt_d = '0;
        end
      end
      IF_RD: begin
        if_ack_c   = 1'b1;
        if_rdata_c = ram_data_in;
        state_d    = IDLE;
      end
      MEM_RD: begin
        mem_ack_c   = 1'b1;
        mem_rdata_c = ram_data_in;
        state_d     = IDLE;
      end
      RMW_WR: begin
        ce_c      = CHIP_ENABLE;
        we_c      = WRITE_ENABLE;
        addr_c    = addr_q;
        data_c    = merged;
        mem_ack_c = 1'b1;
        state_d   = IDLE;
      end
      WR_ACK: begin
        mem_ack_c = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset masks every bus output immediately so an in-flight write never commits.
  assign ram_ce_out    = ce_c & ~reset_in;
  assign ram_we_out    = we_c & ~reset_in;
  assign ram_addr_out  = addr_c & {ADDR_W{~reset_in}};
  assign ram_data_out  = data_c & {DATA_W{~reset_in}};
  assign if_ack_out    = if_ack_c & ~reset_in;
  assign mem_ack_out   = mem_ack_c & ~reset_in;
  assign if_rdata_out  = if_rdata_c & {DATA_W{~reset_in}};
  assign mem_rdata_out = mem_rdata_c & {DATA_W{~reset_in}};
  assign if_stall_out  = if_req_in & ~if_ack_out;
  assign mem_stall_out = mem_req_in & ~mem_ack_out;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: RAM model, transaction-level reference model checked
// every cycle, and directed scenarios with hand-computed expectations.
module tb_ram_bus_arbiter;

  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_be = '0;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        if_stall, mem_stall;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram_mem [0:255];
  logic [31:0] shadow  [0:255];

  ram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk_in        (clock),
    .reset_in      (reset),
    .if_req_in     (if_req),
    .if_addr_in    (if_addr),
    .if_rdata_out  (if_rdata),
    .if_ack_out    (if_ack),
    .mem_req_in    (mem_req),
    .mem_we_in     (mem_we),
    .mem_addr_in   (mem_addr),
    .mem_wdata_in  (mem_wdata),
    .mem_be_in     (mem_be),
    .mem_rdata_out (mem_rdata),
    .mem_ack_out   (mem_ack),
    .if_stall_out  (if_stall),
    .mem_stall_out (mem_stall),
    .ram_ce_out    (ram_ce),
    .ram_we_out    (ram_we),
    .ram_addr_out  (ram_addr),
    .ram_data_out  (ram_wdata),
    .ram_data_in   (ram_rdata)
  );

  always #5 clock = ~clock;

  // Initial RAM image shared by the RAM model and the reference shadow.
  function automatic logic [31:0] initWord(input int idx);
    case (idx)
      4:       return 32'hDEAD_BEEF;
      12:      return 32'h1122_3344;
      16:      return 32'h0BAD_F00D;
      20:      return 32'hA5A5_A5A5;
      default: return 32'(idx);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic ifr, input logic [31:0] ifa, input logic mr,
                               input logic mwe, input logic [31:0] ma,
                               input logic [31:0] mwd, input logic [3:0] mbe);
    if_req = ifr; if_addr = ifa;
    mem_req = mr; mem_we = mwe; mem_addr = ma; mem_wdata = mwd; mem_be = mbe;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Synchronous single-port RAM: read data appears the cycle after the address.
  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] = initWord(i);
    forever begin
      @(posedge clock);
      if (ram_ce && ram_we) ram_mem[ram_addr[9:2]] <= ram_wdata;
      if (ram_ce && !ram_we) ram_rdata <= ram_mem[ram_addr[9:2]];
    end
  end

  // Reference model: each granted access occupies one grant cycle plus one completion cycle.
  initial begin
    int          m_busy, m_kind, m_starve;
    logic [31:0] m_addr, m_wdata, old_w, mrg;
    logic [3:0]  m_be;
    logic        gi, gm;
    logic        e_ce, e_we, e_if_ack, e_mem_ack;
    logic [31:0] e_addr, e_data, e_if_rdata, e_mem_rdata;
    m_busy = 0; m_kind = 0; m_starve = 0;
    m_addr = '0; m_wdata = '0; m_be = '0;
    for (int i = 0; i < 256; i++) shadow[i] = initWord(i);
    forever begin
      @(negedge clock);
      e_ce = 0; e_we = 0; e_if_ack = 0; e_mem_ack = 0;
      e_addr = '0; e_data = '0; e_if_rdata = '0; e_mem_rdata = '0;
      if (reset) begin
        m_busy = 0;
        m_starve = 0;
        checkOutput("rst_ce", {31'b0, ram_ce}, 32'd0);
        checkOutput("rst_we", {31'b0, ram_we}, 32'd0);
        checkOutput("rst_addr", ram_addr, 32'd0);
        checkOutput("rst_data", ram_wdata, 32'd0);
        checkOutput("rst_acks", {30'b0, if_ack, mem_ack}, 32'd0);
        checkOutput("rst_if_rdata", if_rdata, 32'd0);
        checkOutput("rst_mem_rdata", mem_rdata, 32'd0);
      end else begin
        if (m_busy == 0) begin
          gi = if_req && (!mem_req || m_starve == LIMIT);
          gm = mem_req && !gi;
          if (gi) begin
            e_ce = 1; e_addr = if_addr;
            m_kind = 0; m_addr = if_addr; m_busy = 1; m_starve = 0;
          end else if (gm) begin
            m_addr = {mem_addr[31:2], 2'b00}; m_wdata = mem_wdata; m_be = mem_be; m_busy = 1;
            m_starve = if_req ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
            if (!mem_we) begin
              m_kind = 1; e_ce = 1; e_addr = m_addr;
            end else if (mem_be == 4'hF) begin
              m_kind = 2; e_ce = 1; e_we = 1; e_addr = m_addr; e_data = m_wdata;
              shadow[m_addr[9:2]] = m_wdata;
            end else if (mem_be == 4'h0) begin
              m_kind = 3;
            end else begin
              m_kind = 4; e_ce = 1; e_addr = m_addr;
            end
          end else begin
            m_starve = 0;
          end
        end else begin
          m_busy = 0;
          case (m_kind)
            0: begin e_if_ack = 1; e_if_rdata = shadow[m_addr[9:2]]; end
            1: begin e_mem_ack = 1; e_mem_rdata = shadow[m_addr[9:2]]; end
            4: begin
              old_w = shadow[m_addr[9:2]];
              for (int b = 0; b < 4; b++)
                mrg[8*b +: 8] = m_be[b] ? m_wdata[8*b +: 8] : old_w[8*b +: 8];
              e_ce = 1; e_we = 1; e_addr = m_addr; e_data = mrg; e_mem_ack = 1;
              shadow[m_addr[9:2]] = mrg;
            end
            default: e_mem_ack = 1;
          endcase
        end
        checkOutput("m_ce", {31'b0, ram_ce}, {31'b0, e_ce});
        checkOutput("m_we", {31'b0, ram_we}, {31'b0, e_we});
        checkOutput("m_if_ack", {31'b0, if_ack}, {31'b0, e_if_ack});
        checkOutput("m_mem_ack", {31'b0, mem_ack}, {31'b0, e_mem_ack});
        checkOutput("m_if_stall", {31'b0, if_stall}, {31'b0, if_req & ~e_if_ack});
        checkOutput("m_mem_stall", {31'b0, mem_stall}, {31'b0, mem_req & ~e_mem_ack});
        if (e_ce) checkOutput("m_addr", ram_addr, e_addr);
        if (e_we) checkOutput("m_wdata", ram_wdata, e_data);
        if (e_if_ack) checkOutput("m_if_rdata", if_rdata, e_if_rdata);
        if (e_mem_ack) checkOutput("m_mem_rdata", mem_rdata, e_mem_rdata);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  // Directed scenarios; inputs change just after a rising edge, checks sit on the falling edge.
  initial begin
    string got, exp_seq;

    // Requests pending during reset must not reach the bus.
    applyStimulus(1, 32'h10, 1, 0, 32'h20, 0, 0);
    @(negedge clock);
    checkOutput("reset_ce", {31'b0, ram_ce}, 32'd0);
    checkOutput("reset_acks", {30'b0, if_ack, mem_ack}, 32'd0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 0;
    step();

    // IF fetch of 0x10.
    applyStimulus(1, 32'h10, 0, 0, 0, 0, 0);
    @(negedge clock);
    checkOutput("if_c0_ce", {31'b0, ram_ce}, 32'd1);
    checkOutput("if_c0_stall", {31'b0, if_stall}, 32'd1);
    step();
    @(negedge clock);
    checkOutput("if_c1_ack", {31'b0, if_ack}, 32'd1);
    checkOutput("if_c1_rdata", if_rdata, 32'hDEAD_BEEF);
    checkOutput("if_c1_stall", {31'b0, if_stall}, 32'd0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step();

    // Full-word store to 0x20, then load it back.
    applyStimulus(0, 0, 1, 1, 32'h20, 32'h1234_5678, 4'hF);
    @(negedge clock);
    checkOutput("st_c0_we", {31'b0, ram_we}, 32'd1);
    step();
    @(negedge clock);
    checkOutput("st_c1_ack", {31'b0, mem_ack}, 32'd1);
    step();
    applyStimulus(0, 0, 1, 0, 32'h20, 0, 0);
    step();
    @(negedge clock);
    checkOutput("ld20_ack", {31'b0, mem_ack}, 32'd1);
    checkOutput("ld20_rdata", mem_rdata, 32'h1234_5678);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step();

    // Partial store be=0100 over 0x1122_3344 at 0x30, then an empty-enable store.
    applyStimulus(0, 0, 1, 1, 32'h30, 32'h00AB_0000, 4'b0100);
    @(negedge clock);
    checkOutput("rmw_c0_ce", {30'b0, ram_ce, ram_we}, 32'd2);
    step();
    @(negedge clock);
    checkOutput("rmw_c1_we", {31'b0, ram_we}, 32'd1);
    checkOutput("rmw_c1_data", ram_wdata, 32'h11AB_3344);
    checkOutput("rmw_c1_ack", {31'b0, mem_ack}, 32'd1);
    step();
    applyStimulus(0, 0, 1, 1, 32'h30, 32'hFFFF_FFFF, 4'b0000);
    step();
    @(negedge clock);
    checkOutput("be0_ack", {31'b0, mem_ack}, 32'd1);
    step();
    applyStimulus(0, 0, 1, 0, 32'h30, 0, 0);
    step();
    @(negedge clock);
    checkOutput("ld30_rdata", mem_rdata, 32'h11AB_3344);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step();

    // Both requesters held: IF wins once every LIMIT MEM grants.
    got = "";
    exp_seq = "MMMMIMMMMI";
    applyStimulus(1, 32'h10, 1, 0, 32'h40, 0, 0);
    for (int c = 0; c < 40 && got.len() < 10; c++) begin
      @(negedge clock);
      if (mem_ack) got = {got, "M"};
      if (if_ack) got = {got, "I"};
      step();
    end
    checks++;
    if (got != exp_seq) begin
      errors++;
      $display("[TB] FAIL grant_seq actual=%s expected=%s", got, exp_seq);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step();

    // Reset during the RMW write cycle drops the write.
    applyStimulus(0, 0, 1, 1, 32'h50, 32'h0000_00FF, 4'b0001);
    @(negedge clock);
    checkOutput("rst_rmw_c0_ce", {31'b0, ram_ce}, 32'd1);
    step();
    reset = 1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    checkOutput("rst_rmw_we", {31'b0, ram_we}, 32'd0);
    checkOutput("rst_rmw_ack", {31'b0, mem_ack}, 32'd0);
    step();
    reset = 0;
    @(negedge clock);
    checkOutput("post_rst_idle", {29'b0, ram_ce, if_ack, mem_ack}, 32'd0);
    checkOutput("rst_rmw_ram", ram_mem[20], 32'hA5A5_A5A5);
    step();
    applyStimulus(0, 0, 1, 0, 32'h50, 0, 0);
    step();
    @(negedge clock);
    checkOutput("ld50_rdata", mem_rdata, 32'hA5A5_A5A5);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step();

    // Back-to-back loads with the request held: ack, bubble, ack.
    applyStimulus(0, 0, 1, 0, 32'h20, 0, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checkOutput($sformatf("b2b_ack%0d", c), {31'b0, mem_ack}, (c == 1 || c == 3) ? 32'd1 : 32'd0);
      if (c == 1 || c == 3) checkOutput($sformatf("b2b_rdata%0d", c), mem_rdata, 32'h1234_5678);
      if (c < 3) step();
    end
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
